// File: rtl/conv_encoder_tx.sv
// rtl/conv_encoder_tx.sv - rate-1/2 convolutional encoder with zero-tail frame termination
module conv_encoder_tx #(
  parameter int              K      = 9,
  parameter logic [K-1:0]    G0     = 9'o561,
  parameter logic [K-1:0]    G1     = 9'o753,
  parameter int              WD_LEN = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WD_LEN-1:0] frame_len,
  input  logic              in_valid,
  input  logic              in_bit,
  output logic              in_ready,
  output logic              out_valid,
  output logic [1:0]        out_symbol,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              frame_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_TAIL,
    S_DONE
  } state_t;

  state_t            state, state_n;
  logic [K-2:0]      sr, sr_n;
  logic [WD_LEN-1:0] cnt, cnt_n;
  logic [WD_LEN-1:0] len_q, len_n;
  logic              busy_n;
  logic              done_n;
  logic              load;
  logic              load_last;
  logic              slot_free;
  logic              enc_bit;
  logic [K-1:0]      v;
  logic              c0, c1;

  assign slot_free = !out_valid || out_ready;

  // Tail bits are zeros, so the encoder input is only live while in DATA.
  assign enc_bit = (state == S_DATA) ? in_bit : 1'b0;
  assign v       = {enc_bit, sr};
  assign c0      = ^(v & G0);
  assign c1      = ^(v & G1);

  always_comb begin
    state_n   = state;
    sr_n      = sr;
    cnt_n     = cnt;
    len_n     = len_q;
    busy_n    = busy;
    done_n    = 1'b0;
    load      = 1'b0;
    load_last = 1'b0;
    in_ready  = 1'b0;
    case (state)
      S_IDLE: begin
        // frame_done high means the previous frame closed this cycle; hold off one more cycle.
        if (start && !frame_done) begin
          len_n   = frame_len;
          sr_n    = '0;
          cnt_n   = '0;
          busy_n  = 1'b1;
          state_n = (frame_len != '0) ? S_DATA : S_TAIL;
        end
      end
      S_DATA: begin
        in_ready = slot_free;
        if (in_valid && slot_free) begin
          load = 1'b1;
          sr_n = {in_bit, sr[K-2:1]};
          if (cnt == len_q - 1'b1) begin
            cnt_n   = '0;
            state_n = S_TAIL;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      S_TAIL: begin
        if (slot_free) begin
          load = 1'b1;
          sr_n = {1'b0, sr[K-2:1]};
          if (cnt == WD_LEN'(K - 2)) begin
            load_last = 1'b1;
            cnt_n     = '0;
            state_n   = S_DONE;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      S_DONE: begin
        if (out_valid && out_ready && out_last) begin
          done_n  = 1'b1;
          busy_n  = 1'b0;
          sr_n    = '0;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      sr         <= '0;
      cnt        <= '0;
      len_q      <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      sr         <= sr_n;
      cnt        <= cnt_n;
      len_q      <= len_n;
      busy       <= busy_n;
      frame_done <= done_n;
    end
  end

  // Single-entry output register; symbol and last hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_symbol <= 2'b00;
      out_last   <= 1'b0;
    end else if (load) begin
      out_valid  <= 1'b1;
      out_symbol <= {c1, c0};
      out_last   <= load_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_encoder_tx.sv
// tb/tb_conv_encoder_tx.sv - directed and random self-checking bench for conv_encoder_tx
module tb_conv_encoder_tx;

  localparam logic [8:0] G0 = 9'o561;
  localparam logic [8:0] G1 = 9'o753;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] frame_len;
  logic        in_valid;
  logic        in_bit;
  logic        in_ready;
  logic        out_valid;
  logic [1:0]  out_symbol;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        frame_done;

  int nerr    = 0;
  int nchecks = 0;

  logic [1:0] got_sym[$];
  bit         got_last[$];
  logic [1:0] exp_sym[$];
  int         extra_accept;
  int         ready_hi;

  always #5 clk = ~clk;

  conv_encoder_tx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .frame_len  (frame_len),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_symbol (out_symbol),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .frame_done (frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Direct convolution of the zero-padded input with the generator taps.
  task automatic build_exp(input int len, input logic [63:0] bits);
    logic a0, a1;
    exp_sym.delete();
    for (int n = 0; n < len + 8; n++) begin
      a0 = 1'b0;
      a1 = 1'b0;
      for (int j = 0; j < 9; j++) begin
        if (n - j >= 0 && n - j < len) begin
          a0 = a0 ^ (G0[8-j] & bits[n-j]);
          a1 = a1 ^ (G1[8-j] & bits[n-j]);
        end
      end
      exp_sym.push_back({a1, a0});
    end
  endtask

  task automatic compare_frame(input string tag, input bit per_sym);
    int mism;
    int lerr;
    mism = 0;
    lerr = 0;
    chk({tag, "_count"}, got_sym.size(), exp_sym.size());
    for (int i = 0; i < got_sym.size() && i < exp_sym.size(); i++) begin
      if (per_sym) begin
        chk($sformatf("%s_sym%0d", tag, i), got_sym[i], exp_sym[i]);
        chk($sformatf("%s_last%0d", tag, i), got_last[i], (i == exp_sym.size() - 1));
      end else begin
        if (got_sym[i] !== exp_sym[i]) mism++;
        if (got_last[i] !== (i == exp_sym.size() - 1)) lerr++;
      end
    end
    if (!per_sym) begin
      chk({tag, "_symbols"}, mism, 0);
      chk({tag, "_last"}, lerr, 0);
    end
    chk({tag, "_extra_bits"}, extra_accept, 0);
  endtask

  task automatic run_frame(input int len, input logic [63:0] bits, input bit rnd,
                           input int stall_at, input int start_at, input int rst_after);
    int         idx;
    int         cyc;
    bit         done;
    bit         do_rst;
    logic [1:0] hold_sym;
    logic       hold_last;
    got_sym.delete();
    got_last.delete();
    extra_accept = 0;
    ready_hi     = 0;
    idx    = 0;
    cyc    = 0;
    done   = 1'b0;
    do_rst = 1'b0;
    hold_sym  = 2'b00;
    hold_last = 1'b0;
    @(posedge clk); #1;
    start     = 1'b1;
    frame_len = 16'(len);
    @(posedge clk); #1;
    start     = 1'b0;
    frame_len = 16'hFFFF;
    while (!done && !do_rst && cyc < 2000) begin
      in_valid  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_bit    = (idx < len) ? bits[idx] : 1'($urandom_range(0, 1));
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 5) out_ready = 1'b0;
      start     = (cyc == start_at);
      frame_len = (cyc == start_at) ? 16'd3 : 16'hFFFF;
      @(negedge clk);
      if (in_ready) ready_hi++;
      if (in_valid && in_ready) begin
        if (idx >= len) extra_accept++;
        idx++;
      end
      if (out_valid && out_ready) begin
        got_sym.push_back(out_symbol);
        got_last.push_back(out_last);
      end
      if (stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 5) begin
        chk("stall_in_ready", in_ready, 1'b0);
        if (cyc == stall_at) begin
          hold_sym  = out_symbol;
          hold_last = out_last;
          chk("stall_valid", out_valid, 1'b1);
        end else begin
          chk("stall_symbol", out_symbol, hold_sym);
          chk("stall_last", out_last, hold_last);
        end
      end
      if (frame_done) done = 1'b1;
      if (rst_after > 0 && idx == rst_after) do_rst = 1'b1;
      cyc++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (do_rst) begin
      rst_n = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_symbol", out_symbol, 2'b00);
      chk("rst_out_last", out_last, 1'b0);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_frame_done", frame_done, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
    end else begin
      chk("frame_timeout", done, 1'b1);
      chk("busy_after_done", busy, 1'b0);
    end
  endtask

  task automatic check_impulse(input string tag);
    logic [1:0] imp[9];
    imp = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b10, 2'b11};
    chk({tag, "_count"}, got_sym.size(), 9);
    for (int i = 0; i < 9 && i < got_sym.size(); i++) begin
      chk($sformatf("%s_sym%0d", tag, i), got_sym[i], imp[i]);
      chk($sformatf("%s_last%0d", tag, i), got_last[i], (i == 8));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    frame_len = 16'd0;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    out_ready = 1'b0;
    #12;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_symbol", out_symbol, 2'b00);
    chk("reset_out_last", out_last, 1'b0);
    chk("reset_in_ready", in_ready, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_frame_done", frame_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Impulse response
    run_frame(1, 64'h1, 1'b0, -1, -1, 0);
    check_impulse("impulse");

    // Empty frame: only the zero tail
    run_frame(0, 64'h0, 1'b0, -1, -1, 0);
    build_exp(0, 64'h0);
    compare_frame("empty", 1'b1);
    chk("empty_in_ready_never", ready_hi, 0);

    // Backpressure mid-frame
    run_frame(16, 64'hA5C3, 1'b0, 6, -1, 0);
    build_exp(16, 64'hA5C3);
    compare_frame("backpressure", 1'b1);

    // Start pulse during a frame is ignored
    run_frame(16, 64'h1234, 1'b0, -1, 5, 0);
    build_exp(16, 64'h1234);
    compare_frame("ignored_start", 1'b0);

    // Reset after the 10th of 32 bits, then the impulse again
    run_frame(32, 64'hDEADBEEF, 1'b0, -1, -1, 10);
    run_frame(1, 64'h1, 1'b0, -1, -1, 0);
    check_impulse("post_reset");

    // Random frames with random handshakes
    for (int f = 0; f < 200; f++) begin
      logic [63:0] rb;
      rb = {$urandom, $urandom};
      run_frame(64, rb, 1'b1, -1, -1, 0);
      build_exp(64, rb);
      compare_frame($sformatf("rand%0d", f), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
